ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Purpose : two-port round-robin arbiter in front of one shared single-port synchronous RAM.
// Latency : request sampled at E0, RAM access in the following cycle (E1 edge), read data/rvalid registered at E2.
// Backpr. : one access per two cycles; a losing or late requester simply keeps reqX high until gntX pulses.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req/we/addr/wdata{0,1}     - per-port request, held stable until the matching grant
//   gnt{0,1}                   - one-cycle grant pulse in the ACCESS cycle
//   rvalid{0,1}, rdata{0,1}    - one-cycle read-valid pulse, read data held between reads
//   ram_we/ram_addr/ram_din    - shared RAM command, ram_dout - RAM read data (one cycle after address edge)
module ram_arbiter #(
    parameter int ANCHO = 32,
    parameter int LARGO = 1024,
    localparam int AW = $clog2(LARGO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [ANCHO-1:0] wdata0,
    input  logic [ANCHO-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [ANCHO-1:0] rdata0,
    output logic [ANCHO-1:0] rdata1,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [ANCHO-1:0] ram_din,
    input  logic [ANCHO-1:0] ram_dout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic             last_q,      last_d;       // 1 = port 1 was granted last
    logic             cmd_we_q,    cmd_we_d;
    logic             cmd_port_q,  cmd_port_d;
    logic [AW-1:0]    cmd_addr_q,  cmd_addr_d;
    logic [ANCHO-1:0] cmd_wdata_q, cmd_wdata_d;
    logic             gnt0_q,      gnt0_d;
    logic             gnt1_q,      gnt1_d;
    logic             ram_we_q,    ram_we_d;
    logic             rvalid0_q,   rvalid0_d;
    logic             rvalid1_q,   rvalid1_d;
    logic [ANCHO-1:0] rdata0_q,    rdata0_d;
    logic [ANCHO-1:0] rdata1_q,    rdata1_d;

    logic any_req;
    logic pick1;
    logic arb_edge;

    always_comb begin
        any_req  = req0 | req1;
        // On a tie the port that did not win last time goes first.
        pick1    = req1 & (~req0 | ~last_q);
        // Requests are only looked at on the edges that leave IDLE or RESP.
        arb_edge = (state_q != ST_ACCESS) & any_req;

        state_d     = state_q;
        last_d      = last_q;
        cmd_we_d    = cmd_we_q;
        cmd_port_d  = cmd_port_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        ram_we_d    = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // RAM output now reflects the address presented during ACCESS.
                if (!cmd_we_q) begin
                    if (cmd_port_q) begin
                        rdata1_d  = ram_dout;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = ram_dout;
                        rvalid0_d = 1'b1;
                    end
                end
                state_d = any_req ? ST_ACCESS : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arb_edge) begin
            last_d      = pick1;
            cmd_port_d  = pick1;
            cmd_we_d    = pick1 ? we1    : we0;
            cmd_addr_d  = pick1 ? addr1  : addr0;
            cmd_wdata_d = pick1 ? wdata1 : wdata0;
            gnt0_d      = ~pick1;
            gnt1_d      = pick1;
            ram_we_d    = pick1 ? we1    : we0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_port_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            ram_we_q    <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_port_q  <= cmd_port_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            ram_we_q    <= ram_we_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // The command register doubles as the RAM address/data drive, so both
    // naturally hold their last value outside ACCESS.
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = cmd_addr_q;
    assign ram_din  = cmd_wdata_q;

endmodule
